// File: rtl/byte_to_word_32b_if.sv
// Byte-lane input / word output bundle for the byte_to_word_32b packer.
// err_partial exists only when PARTIAL_ERR_EN is defined.
interface byte_to_word_32b_if #(
    parameter int BYTE_W = 8,
    parameter int NBYTES = 4
);
    logic                     valid_in;
    logic [BYTE_W-1:0]        data_in;
    logic                     valid_out;
    logic [BYTE_W*NBYTES-1:0] data_out;
`ifdef PARTIAL_ERR_EN
    logic                     err_partial;

    modport master (output valid_in, output data_in,
                    input  valid_out, input data_out, input err_partial);
    modport slave  (input  valid_in, input data_in,
                    output valid_out, output data_out, output err_partial);
`else
    modport master (output valid_in, output data_in,
                    input  valid_out, input data_out);
    modport slave  (input  valid_in, input data_in,
                    output valid_out, output data_out);
`endif
endinterface

// File: rtl/byte_to_word_32b.sv
// Packs NBYTES consecutive valid bytes (first byte in the top lane) into one word.
// Optional feature macro: PARTIAL_ERR_EN adds an err_partial pulse when a partial word is dropped.
module byte_to_word_32b #(
    parameter int BYTE_W = 8,
    parameter int NBYTES = 4
) (
    input  logic              clk_4f,
    input  logic              reset,
    byte_to_word_32b_if.slave bus
);
    localparam int WORD_W = BYTE_W * NBYTES;
    localparam int CW     = $clog2(NBYTES);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
`ifdef PARTIAL_ERR_EN
    logic              err_q, err_d;
`endif
    logic [CW-1:0]     lane;

    // Lane written by the byte arriving now; count tracks bytes already held.
    assign lane = LAST_IDX - count_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = 1'b0;
`ifdef PARTIAL_ERR_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    shadow_d[WORD_W-1 -: BYTE_W] = bus.data_in;
                    count_d = CW'(1);
                    state_d = COLLECT;
                end
            end
            default: begin
                if (bus.valid_in) begin
                    shadow_d[int'(lane)*BYTE_W +: BYTE_W] = bus.data_in;
                    if (count_q == LAST_IDX) begin
                        word_d  = shadow_d;
                        valid_d = 1'b1;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    // Gap mid-word: the partial word is abandoned; shadow lanes are left stale.
                    count_d = '0;
                    state_d = IDLE;
`ifdef PARTIAL_ERR_EN
                    err_d   = 1'b1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
`ifdef PARTIAL_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
`ifdef PARTIAL_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.data_out  = word_q;
`ifdef PARTIAL_ERR_EN
    assign bus.err_partial = err_q;
`endif
endmodule

// File: tb/tb_byte_to_word_32b.sv
// Directed vector table plus randomized traffic against a queue-based reference packer.
module tb_byte_to_word_32b;
    logic clk_4f;
    logic reset;

    byte_to_word_32b_if #(.BYTE_W(8), .NBYTES(4)) bif ();

    byte_to_word_32b #(.BYTE_W(8), .NBYTES(4)) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bif)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic        rst;
        logic        vin;
        logic [7:0]  din;
        logic        expValid;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    logic [7:0]  mBytes[$];
    logic [31:0] mWord;
    logic        mValid;
    logic        mErr;

    task automatic addRow(input logic r, input logic v, input logic [7:0] d,
                          input logic ev, input logic [31:0] ed, input logic ee);
        vec_t row;
        row.rst = r; row.vin = v; row.din = d;
        row.expValid = ev; row.expData = ed; row.expErr = ee;
        vecs.push_back(row);
    endtask

    // Drive one cycle of inputs, let the edge pass, and settle before sampling.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        reset        = r;
        bif.valid_in = v;
        bif.data_in  = d;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference: collect bytes in a list; four bytes make a word, a gap discards the list.
    task automatic modelStep(input logic r, input logic v, input logic [7:0] d);
        mValid = 1'b0;
        mErr   = 1'b0;
        if (r) begin
            mBytes.delete();
            mWord = 32'h0;
        end else if (v) begin
            mBytes.push_back(d);
            if (mBytes.size() == 4) begin
                mWord  = {mBytes[0], mBytes[1], mBytes[2], mBytes[3]};
                mValid = 1'b1;
                mBytes.delete();
            end
        end else if (mBytes.size() != 0) begin
            mBytes.delete();
            mErr = 1'b1;
        end
    endtask

    task automatic checkAll(input string tag, input logic ev, input logic [31:0] ed, input logic ee);
        checkOutput({tag, " valid_out"}, {31'h0, bif.valid_out}, {31'h0, ev});
        checkOutput({tag, " data_out"}, bif.data_out, ed);
`ifdef PARTIAL_ERR_EN
        checkOutput({tag, " err_partial"}, {31'h0, bif.err_partial}, {31'h0, ee});
`else
        if (ee === 1'bx) $display("[TB] unexpected X in err expectation");
`endif
    endtask

    initial begin
        logic        r, v;
        logic [7:0]  d;
        logic [31:0] held;

        reset = 1'b1;
        bif.valid_in = 1'b0;
        bif.data_in  = 8'h00;

        // Reset and idle release
        addRow(1, 0, 8'h00, 0, 32'h0, 0);
        addRow(1, 0, 8'h00, 0, 32'h0, 0);
        addRow(0, 0, 8'h00, 0, 32'h0, 0);
        addRow(0, 0, 8'h00, 0, 32'h0, 0);
        // Single word
        addRow(0, 1, 8'hFF, 0, 32'h0, 0);
        addRow(0, 1, 8'hAA, 0, 32'h0, 0);
        addRow(0, 1, 8'hFF, 0, 32'h0, 0);
        addRow(0, 1, 8'hBB, 1, 32'hFFAAFFBB, 0);
        addRow(0, 0, 8'h00, 0, 32'hFFAAFFBB, 0);
        // Back-to-back words
        addRow(0, 1, 8'hFF, 0, 32'hFFAAFFBB, 0);
        addRow(0, 1, 8'hAA, 0, 32'hFFAAFFBB, 0);
        addRow(0, 1, 8'hFF, 0, 32'hFFAAFFBB, 0);
        addRow(0, 1, 8'hBB, 1, 32'hFFAAFFBB, 0);
        addRow(0, 1, 8'hDD, 0, 32'hFFAAFFBB, 0);
        addRow(0, 1, 8'hCC, 0, 32'hFFAAFFBB, 0);
        addRow(0, 1, 8'hDD, 0, 32'hFFAAFFBB, 0);
        addRow(0, 1, 8'hEE, 1, 32'hDDCCDDEE, 0);
        // Partial word dropped by a gap
        addRow(0, 1, 8'h01, 0, 32'hDDCCDDEE, 0);
        addRow(0, 1, 8'h0F, 0, 32'hDDCCDDEE, 0);
        addRow(0, 0, 8'h00, 0, 32'hDDCCDDEE, 1);
        addRow(0, 1, 8'h0A, 0, 32'hDDCCDDEE, 0);
        addRow(0, 1, 8'h03, 0, 32'hDDCCDDEE, 0);
        addRow(0, 1, 8'h01, 0, 32'hDDCCDDEE, 0);
        addRow(0, 1, 8'h0F, 1, 32'h0A03010F, 0);
        // Reset mid-word
        addRow(0, 1, 8'h11, 0, 32'h0A03010F, 0);
        addRow(0, 1, 8'h22, 0, 32'h0A03010F, 0);
        addRow(0, 1, 8'h33, 0, 32'h0A03010F, 0);
        addRow(1, 0, 8'h00, 0, 32'h0, 0);
        addRow(0, 1, 8'h44, 0, 32'h0, 0);
        addRow(0, 1, 8'h55, 0, 32'h0, 0);
        addRow(0, 1, 8'h66, 0, 32'h0, 0);
        addRow(0, 1, 8'h77, 1, 32'h44556677, 0);
        // Idle hold
        for (int i = 0; i < 5; i++) addRow(0, 0, 8'h00, 0, 32'h44556677, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].vin, vecs[i].din);
            checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData, vecs[i].expErr);
        end

        // Hand sequence: gap then immediate restart, stale shadow lanes must be overwritten
        applyStimulus(0, 1, 8'hA1);
        applyStimulus(0, 1, 8'hB2);
        applyStimulus(0, 1, 8'hC3);
        applyStimulus(0, 0, 8'h00);
        checkAll("gap3", 0, 32'h44556677, 1);
        applyStimulus(0, 1, 8'h5A);
        checkAll("restart0", 0, 32'h44556677, 0);
        applyStimulus(0, 1, 8'h00);
        applyStimulus(0, 1, 8'h00);
        applyStimulus(0, 1, 8'h00);
        checkAll("restart3", 1, 32'h5A000000, 0);
        applyStimulus(0, 0, 8'h00);
        checkAll("idleAfter", 0, 32'h5A000000, 0);

        // Randomized traffic against the reference model, starting from a clean reset
        applyStimulus(1, 0, 8'h00);
        modelStep(1, 0, 8'h00);
        checkAll("rndReset", 0, mWord, 0);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 85);
            d = 8'($urandom_range(0, 255));
            held = mWord;
            applyStimulus(r, v, d);
            modelStep(r, v, d);
            checkAll($sformatf("rnd%0d", i), mValid, mWord, mErr);
            if (!mValid && !r) checkOutput($sformatf("rnd%0d hold", i), bif.data_out, held);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
